// File: rtl/serial_adder.sv
// -----------------------------------------------------------------------------
// serial_adder
//   Bit-serial (slice-serial) adder. Each clock adds one BITS_PER_CYCLE-wide
//   slice of the captured operands, LSB slice first, with a carry register
//   chaining the slices. The result registers update only when the last slice
//   completes, so sum/c_out/overflow hold the previous result while running.
//
//   Parameters
//     WIDTH           operand/sum width (>= 1)
//     BITS_PER_CYCLE  slice width; WIDTH must be a multiple of it
//                     K = WIDTH / BITS_PER_CYCLE slices per addition
//
//   Optional feature
//     SERIAL_ADDER_SUB_EN  adds input 'sub'. When sub is captured high the
//                          operation is a - b - c_in, done as a + ~b + ~c_in,
//                          and c_out = 1 means "no borrow".
//
//   Ports
//     clk       in   rising-edge clock
//     rst_n     in   synchronous active-low reset
//     start     in   request an addition (accepted only in IDLE)
//     sub       in   subtract select (only with SERIAL_ADDER_SUB_EN)
//     a, b      in   operands [WIDTH-1:0]
//     c_in      in   carry into bit 0
//     sum       out  registered result [WIDTH-1:0]
//     c_out     out  carry out of bit WIDTH-1
//     overflow  out  signed overflow (carry into MSB xor carry out of MSB)
//     busy      out  high while slices are being processed
//     done      out  one-cycle pulse when the new result is valid
//
//   State | meaning
//   ------+--------------------------------------------------------------
//   IDLE  | waiting for start; operands captured on the accepting edge
//   RUN   | one slice added per edge; last slice loads the result regs
//   DONE  | result valid, done pulse; back to IDLE on the next edge
// -----------------------------------------------------------------------------
module serial_adder #(
    parameter int WIDTH          = 8,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             overflow,
    output logic             busy,
    output logic             done
);

    localparam int BPC   = BITS_PER_CYCLE;
    localparam int K     = WIDTH / BPC;
    localparam int CNT_W = (K > 1) ? $clog2(K) : 1;
    localparam logic [CNT_W-1:0] LAST_SLICE = CNT_W'(K - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;

    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_acc;
    logic               r_carry;
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]   r_sum;
    logic               r_c_out;
    logic               r_ovf;

    logic [WIDTH-1:0]   w_b_op;
    logic               w_cin_op;
    logic               w_last;
    logic [BPC:0]       w_slice;
    logic [WIDTH+BPC-1:0] w_acc_cat;
    logic [WIDTH-1:0]   w_acc_nxt;
    logic               w_msb_cin;

`ifdef SERIAL_ADDER_SUB_EN
    // Subtraction reuses the adder: a - b - c_in == a + ~b + ~c_in.
    assign w_b_op   = sub ? ~b : b;
    assign w_cin_op = sub ? ~c_in : c_in;
`else
    assign w_b_op   = b;
    assign w_cin_op = c_in;
`endif

    assign w_last  = (r_cnt == LAST_SLICE);

    // Current slice sits in the low bits of the shifting operand registers.
    assign w_slice = {1'b0, r_a[BPC-1:0]} + {1'b0, r_b[BPC-1:0]}
                   + {{BPC{1'b0}}, r_carry};

    // New slice enters at the top of the accumulator; after K slices the
    // first slice has reached bit 0. Works for K == 1 as well.
    assign w_acc_cat = {w_slice[BPC-1:0], r_acc};
    assign w_acc_nxt = w_acc_cat[WIDTH+BPC-1:BPC];

    // On the last slice, bit BPC-1 of the slice is the sum MSB; the carry
    // into it is recovered from the full-adder relation s = a ^ b ^ cin.
    assign w_msb_cin = r_a[BPC-1] ^ r_b[BPC-1] ^ w_slice[BPC-1];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (start) w_state_nxt = RUN;
            RUN:     if (w_last) w_state_nxt = DONE;
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_a     <= '0;
            r_b     <= '0;
            r_acc   <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            r_sum   <= '0;
            r_c_out <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_a     <= a;
                        r_b     <= w_b_op;
                        r_carry <= w_cin_op;
                        r_cnt   <= '0;
                    end
                end
                RUN: begin
                    r_a     <= r_a >> BPC;
                    r_b     <= r_b >> BPC;
                    r_carry <= w_slice[BPC];
                    r_acc   <= w_acc_nxt;
                    r_cnt   <= r_cnt + CNT_W'(1);
                    if (w_last) begin
                        r_sum   <= w_acc_nxt;
                        r_c_out <= w_slice[BPC];
                        r_ovf   <= w_msb_cin ^ w_slice[BPC];
                    end
                end
                default: ;
            endcase
        end
    end

    assign sum      = r_sum;
    assign c_out    = r_c_out;
    assign overflow = r_ovf;
    assign busy     = (r_state == RUN);
    assign done     = (r_state == DONE);

endmodule

// File: tb/tb_serial_adder.sv
module tb_serial_adder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // index 0: WIDTH=8 BPC=1, index 1: WIDTH=1 BPC=1, index 2: WIDTH=8 BPC=4
    logic       rst_n [3];
    logic       start [3];
    logic [7:0] opa   [3];
    logic [7:0] opb   [3];
    logic       cin   [3];
    logic       sub   [3];

    logic [7:0] sum0, sum2;
    logic       sum1;
    logic       co0, co1, co2, ov0, ov1, ov2, bz0, bz1, bz2, dn0, dn1, dn2;

    logic [9:0] last_res [3];

    typedef struct {
        int         inst;
        logic [9:0] res;
    } exp_t;
    exp_t sbq[$];

    serial_adder #(.WIDTH(8), .BITS_PER_CYCLE(1)) u_w8b1 (
        .clk(clk), .rst_n(rst_n[0]), .start(start[0]),
`ifdef SERIAL_ADDER_SUB_EN
        .sub(sub[0]),
`endif
        .a(opa[0]), .b(opb[0]), .c_in(cin[0]),
        .sum(sum0), .c_out(co0), .overflow(ov0), .busy(bz0), .done(dn0));

    serial_adder #(.WIDTH(1), .BITS_PER_CYCLE(1)) u_w1b1 (
        .clk(clk), .rst_n(rst_n[1]), .start(start[1]),
`ifdef SERIAL_ADDER_SUB_EN
        .sub(sub[1]),
`endif
        .a(opa[1][0]), .b(opb[1][0]), .c_in(cin[1]),
        .sum(sum1), .c_out(co1), .overflow(ov1), .busy(bz1), .done(dn1));

    serial_adder #(.WIDTH(8), .BITS_PER_CYCLE(4)) u_w8b4 (
        .clk(clk), .rst_n(rst_n[2]), .start(start[2]),
`ifdef SERIAL_ADDER_SUB_EN
        .sub(sub[2]),
`endif
        .a(opa[2]), .b(opb[2]), .c_in(cin[2]),
        .sum(sum2), .c_out(co2), .overflow(ov2), .busy(bz2), .done(dn2));

    // {busy, done, overflow, c_out, sum[7:0]}
    function automatic logic [11:0] outs(input int inst);
        case (inst)
            0:       return {bz0, dn0, ov0, co0, sum0};
            1:       return {bz1, dn1, ov1, co1, 7'b0, sum1};
            default: return {bz2, dn2, ov2, co2, sum2};
        endcase
    endfunction

    // Reference: {overflow, c_out, sum}
    function automatic logic [9:0] model(input int inst, input logic [7:0] a,
                                         input logic [7:0] b, input logic ci,
                                         input logic sb);
        logic [7:0] bb;
        logic       c;
        logic [1:0] f1;
        logic [8:0] f8;
        logic       v;
        bb = sb ? ~b : b;
        c  = sb ? ~ci : ci;
        if (inst == 1) begin
            f1 = {1'b0, a[0]} + {1'b0, bb[0]} + {1'b0, c};
            v  = (a[0] == bb[0]) && (f1[0] != a[0]);
            return {v, f1[1], 7'b0, f1[0]};
        end
        f8 = {1'b0, a} + {1'b0, bb} + {8'b0, c};
        v  = (a[7] == bb[7]) && (f8[7] != a[7]);
        return {v, f8[8], f8[7:0]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge. Drives start, then follows the operation to done.
    task automatic op(input int inst, input logic [7:0] a, input logic [7:0] b,
                      input logic ci, input logic sb, input int k, input bit poke);
        exp_t        e;
        exp_t        got;
        logic [11:0] o;
        bit          seen;
        start[inst] = 1'b1;
        opa[inst]   = a;
        opb[inst]   = b;
        cin[inst]   = ci;
        sub[inst]   = sb;
        e.inst = inst;
        e.res  = model(inst, a, b, ci, sb);
        sbq.push_back(e);
        @(posedge clk);
        seen = 1'b0;
        for (int n = 0; n < 40 && !seen; n++) begin
            @(negedge clk);
            if (n == 0) begin
                // later requests and operand changes must not disturb this op
                start[inst] = poke;
                opa[inst]   = 8'($urandom);
                opb[inst]   = 8'($urandom);
                cin[inst]   = ~ci;
                sub[inst]   = ~sb;
            end
            if (n == 1) start[inst] = 1'b0;
            o = outs(inst);
            if (o[10]) begin
                seen = 1'b1;
                chk("done_latency", 32'(n), 32'(k));
                chk("busy_in_done", 32'(o[11]), 32'(0));
                if (sbq.size() == 0) begin
                    chk("scoreboard_nonempty", 32'(sbq.size()), 32'(1));
                end else begin
                    got = sbq.pop_front();
                    chk("result", 32'(o[9:0]), 32'(got.res));
                    last_res[inst] = got.res;
                end
            end else begin
                chk("busy_run", 32'(o[11]), 32'(1));
                if (n == 0) chk("hold_prev", 32'(o[9:0]), 32'(last_res[inst]));
            end
        end
        chk("done_seen", 32'(seen), 32'(1));
        @(negedge clk);
        o = outs(inst);
        chk("done_one_cycle", 32'(o[11:10]), 32'(0));
    endtask

    initial begin
        logic [11:0] o;
        for (int i = 0; i < 3; i++) begin
            rst_n[i] = 1'b0; start[i] = 1'b0; opa[i] = '0; opb[i] = '0;
            cin[i] = 1'b0; sub[i] = 1'b0; last_res[i] = '0;
        end
        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++) chk("reset_state", 32'(outs(i)), 32'(0));
        for (int i = 0; i < 3; i++) rst_n[i] = 1'b1;
        @(negedge clk);

        op(0, 8'h00, 8'h00, 1'b0, 1'b0, 8, 1'b0);
        op(0, 8'hFF, 8'h01, 1'b0, 1'b0, 8, 1'b0);
        op(0, 8'h80, 8'h80, 1'b0, 1'b0, 8, 1'b0);
        op(0, 8'hA5, 8'h5A, 1'b1, 1'b0, 8, 1'b0);
        op(0, 8'h7F, 8'h01, 1'b0, 1'b0, 8, 1'b0);

        for (int v = 0; v < 8; v++) begin
            logic [2:0] bits;
            bits = 3'(v);
            op(1, {7'b0, bits[2]}, {7'b0, bits[1]}, bits[0], 1'b0, 1, 1'b0);
        end

        op(2, 8'h3C, 8'hC4, 1'b1, 1'b0, 2, 1'b1);
        op(2, 8'h7F, 8'h7F, 1'b1, 1'b0, 2, 1'b1);

        // Reset on the third RUN cycle aborts the op without a done pulse.
        start[0] = 1'b1; opa[0] = 8'h11; opb[0] = 8'h22; cin[0] = 1'b0;
        @(posedge clk);
        @(negedge clk);
        start[0] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n[0] = 1'b0;
        @(negedge clk);
        chk("reset_abort_outputs", 32'(outs(0)), 32'(0));
        @(negedge clk);
        chk("reset_hold_done", 32'(dn0), 32'(0));
        last_res[0] = '0;
        rst_n[0] = 1'b1;
        op(0, 8'h02, 8'h03, 1'b0, 1'b0, 8, 1'b0);
        repeat (3) begin
            @(negedge clk);
            o = outs(0);
            chk("idle_after_op", 32'(o[11:10]), 32'(0));
        end

`ifdef SERIAL_ADDER_SUB_EN
        op(0, 8'h05, 8'h07, 1'b0, 1'b1, 8, 1'b0);
        op(0, 8'h09, 8'h03, 1'b0, 1'b1, 8, 1'b0);
`endif

        chk("scoreboard_drained", 32'(sbq.size()), 32'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
        $fatal(1);
    end

endmodule
